// File: rtl/uart_upgrade_loader.sv
// UART firmware-upgrade responder: parses SYNC/ADDR/LEN/DATA/CSUM frames into memory writes, ACK/NAK.
// Optional inter-byte timeout enabled by defining UPG_TIMEOUT_EN.
module uart_upgrade_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  SYNC_BYTE   = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upgrade_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StAddr0, StAddr1, StLen0, StLen1, StData, StCsum, StResp
  } state_e;

  state_e            state_q;
  logic [15:0]       addr_q;
  logic [15:0]       len_q;
  logic [15:0]       word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       shift_q;
  logic [7:0]        csum_q;
  logic              ok_q;
  logic [ADDR_W-1:0] word_addr;
  logic              in_frame;

  // Frame address is truncated (or extended) to the memory port width; wrap is silent.
  assign word_addr = ADDR_W'(addr_q) + ADDR_W'(word_idx_q);
  assign in_frame  = (state_q != StIdle) && (state_q != StResp);

`ifdef UPG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;

  assign tmo_hit = in_frame && !rx_valid && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      ok_q       <= 1'b0;
      tx_wr_en   <= 1'b0;
      tx_data    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= upgrade_en;

      if (!upgrade_en) begin
        // Abandoning a partial frame is reported; a pending response is silently dropped.
        err     <= in_frame;
        state_q <= StIdle;
`ifdef UPG_TIMEOUT_EN
      end else if (tmo_hit) begin
        err     <= 1'b1;
        state_q <= StIdle;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              csum_q  <= '0;
              state_q <= StAddr0;
            end
          end
          StAddr0: begin
            if (rx_valid) begin
              addr_q[7:0] <= rx_data;
              csum_q      <= csum_q ^ rx_data;
              state_q     <= StAddr1;
            end
          end
          StAddr1: begin
            if (rx_valid) begin
              addr_q[15:8] <= rx_data;
              csum_q       <= csum_q ^ rx_data;
              state_q      <= StLen0;
            end
          end
          StLen0: begin
            if (rx_valid) begin
              len_q[7:0] <= rx_data;
              csum_q     <= csum_q ^ rx_data;
              state_q    <= StLen1;
            end
          end
          StLen1: begin
            if (rx_valid) begin
              len_q[15:8] <= rx_data;
              csum_q      <= csum_q ^ rx_data;
              word_idx_q  <= '0;
              byte_cnt_q  <= '0;
              state_q     <= ({rx_data, len_q[7:0]} == 16'd0) ? StCsum : StData;
            end
          end
          StData: begin
            if (rx_valid) begin
              csum_q     <= csum_q ^ rx_data;
              shift_q    <= {rx_data, shift_q[23:8]};
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_addr;
                mem_wdata <= {rx_data, shift_q};
                if (word_idx_q == len_q - 16'd1) begin
                  state_q <= StCsum;
                end else begin
                  word_idx_q <= word_idx_q + 16'd1;
                end
              end
            end
          end
          StCsum: begin
            if (rx_valid) begin
              ok_q    <= (rx_data == csum_q);
              state_q <= StResp;
            end
          end
          StResp: begin
            if (!tx_busy) begin
              tx_wr_en <= 1'b1;
              tx_data  <= ok_q ? 8'h06 : 8'h15;
              done     <= ok_q;
              err      <= !ok_q;
              state_q  <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_upgrade_loader.sv
// Self-checking bench for uart_upgrade_loader: table vectors, corner sequences and random frames
// checked against a byte-list frame model.
module tb_uart_upgrade_loader;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TMO    = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              upgrade_en = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_busy = 1'b0;
  logic              tx_wr_en;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  uart_upgrade_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TMO),
    .SYNC_BYTE  (8'h5A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upgrade_en(upgrade_en),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_wr_en  (tx_wr_en),
    .tx_data   (tx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Observed activity, sampled on the falling edge.
  logic [47:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int done_cnt = 0, err_cnt = 0, bad_pulse = 0, busy_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      if (tx_wr_en) tx_q.push_back(tx_data);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tx_wr_en && tx_busy) busy_viol++;
      if ((done && !(tx_wr_en && tx_data == 8'h06)) || (tx_wr_en && tx_data == 8'h06 && !done) ||
          (tx_wr_en && tx_data == 8'h15 && !err)) bad_pulse++;
    end
  end

  task automatic clear_obs();
    wr_q.delete();
    tx_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];
  logic [47:0] exp_wr_q[$];

  task automatic make_frame(input logic [15:0] a, input logic [7:0] flip);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(words_q.size());
    frame_q.delete();
    frame_q.push_back(8'h5A);
    frame_q.push_back(a[7:0]);
    frame_q.push_back(a[15:8]);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words_q[k]) for (int b = 0; b < 4; b++) frame_q.push_back(words_q[k][8*b +: 8]);
    x = 8'h00;
    for (int j = 1; j < frame_q.size(); j++) x ^= frame_q[j];
    frame_q.push_back(x ^ flip);
  endtask

  task automatic send_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i <= hi; i++) begin
      send_byte(frame_q[i]);
      if (max_gap > 0) tick($urandom_range(max_gap, 0));
    end
  endtask

  task automatic wait_tx(input int budget);
    int i;
    i = 0;
    while (tx_q.size() == 0 && i < budget) begin
      tick(1);
      i++;
    end
    tick(3);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] resp);
    check({tag, " write count"}, wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
      check($sformatf("%s write %0d addr/data", tag, i), wr_q[i], exp_wr_q[i]);
    check({tag, " tx count"}, tx_q.size(), 1);
    if (tx_q.size() > 0) check({tag, " tx byte"}, tx_q[0], resp);
    check({tag, " done pulses"}, done_cnt, (resp == 8'h06) ? 1 : 0);
    check({tag, " err pulses"}, err_cnt, (resp == 8'h15) ? 1 : 0);
  endtask

  // Reference model: parses the byte list directly from the frame rules.
  task automatic model_frame(output logic [7:0] resp);
    int s, n, wa, base;
    logic [15:0] a;
    logic [7:0]  x;
    exp_wr_q.delete();
    s = 0;
    while (s < frame_q.size() && frame_q[s] != 8'h5A) s++;
    a = {frame_q[s+2], frame_q[s+1]};
    n = int'({frame_q[s+4], frame_q[s+3]});
    for (int k = 0; k < n; k++) begin
      wa   = (int'(a) + k) % (1 << ADDR_W);
      base = s + 5 + 4 * k;
      exp_wr_q.push_back({wa[15:0], frame_q[base+3], frame_q[base+2], frame_q[base+1],
                          frame_q[base]});
    end
    x = 8'h00;
    for (int j = s + 1; j < frame_q.size() - 1; j++) x ^= frame_q[j];
    resp = (x == frame_q[frame_q.size()-1]) ? 8'h06 : 8'h15;
  endtask

  typedef struct {
    logic [15:0] addr;
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  flip;
    int          busy;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  resp;
  } vec_t;

  vec_t vecs[5];

  task automatic load_vec(input int i);
    words_q.delete();
    exp_wr_q.delete();
    if (vecs[i].len > 0) words_q.push_back(vecs[i].w0);
    if (vecs[i].len > 1) words_q.push_back(vecs[i].w1);
    make_frame(vecs[i].addr, vecs[i].flip);
    if (vecs[i].len > 0) exp_wr_q.push_back({vecs[i].a0, vecs[i].w0});
    if (vecs[i].len > 1) exp_wr_q.push_back({vecs[i].a1, vecs[i].w1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] resp;
    logic [7:0] junk;
    int         len;

    vecs[0] = '{16'h0010, 2, 32'h11223344, 32'hDEADBEEF, 8'h00, 0,  16'h0010, 16'h0011, 8'h06};
    vecs[1] = '{16'h0010, 2, 32'h11223344, 32'hDEADBEEF, 8'h01, 0,  16'h0010, 16'h0011, 8'h15};
    vecs[2] = '{16'h0100, 0, 32'h0,        32'h0,        8'h00, 0,  16'h0,    16'h0,    8'h06};
    vecs[3] = '{16'hFFFF, 2, 32'hA5A5A5A5, 32'h0BADF00D, 8'h00, 0,  16'hFFFF, 16'h0000, 8'h06};
    vecs[4] = '{16'h0010, 2, 32'h11223344, 32'hDEADBEEF, 8'h00, 50, 16'h0010, 16'h0011, 8'h06};

    // Reset state
    tick(3);
    check("reset tx_wr_en", tx_wr_en, 0);
    check("reset tx_data", tx_data, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset cpu_hold", cpu_hold, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    tick(1);
    check("cpu_hold follows upgrade_en", cpu_hold, 1);
    tick(2);

    // Table vectors, bytes back-to-back
    foreach (vecs[i]) begin
      clear_obs();
      load_vec(i);
      tx_busy = (vecs[i].busy > 0);
      send_range(0, frame_q.size() - 1, 0);
      if (vecs[i].busy > 0) begin
        tick(vecs[i].busy);
        check($sformatf("vec%0d tx held while busy", i), tx_q.size(), 0);
        tx_busy = 1'b0;
      end
      wait_tx(50);
      check_frame($sformatf("vec%0d", i), vecs[i].resp);
    end

    // Leading junk before SYNC
    clear_obs();
    load_vec(0);
    frame_q.push_front(8'hFF);
    frame_q.push_front(8'h00);
    send_range(0, frame_q.size() - 1, 0);
    wait_tx(50);
    check_frame("junk lead", 8'h06);

    // Minimum response latency: tx_wr_en two cycles after the CSUM byte
    clear_obs();
    load_vec(0);
    send_range(0, frame_q.size() - 1, 0);
    tick(1);
    check("latency 1 cycle no tx", tx_q.size(), 0);
    tick(1);
    check("latency 2 cycles tx", tx_q.size(), 1);
    tick(3);

    // Stall mid-header
    clear_obs();
    load_vec(0);
    send_range(0, 2, 0);
    tick(TMO + 1);
`ifdef UPG_TIMEOUT_EN
    check("timeout err pulses", err_cnt, 1);
    check("timeout no tx", tx_q.size(), 0);
    clear_obs();
    send_range(0, frame_q.size() - 1, 0);
`else
    check("stall no err", err_cnt, 0);
    send_range(3, frame_q.size() - 1, 0);
`endif
    wait_tx(50);
    check_frame("after stall", 8'h06);

    // upgrade_en dropped mid-DATA
    clear_obs();
    load_vec(0);
    send_range(0, 6, 0);
    upgrade_en = 1'b0;
    check("cpu_hold before drop edge", cpu_hold, 1);
    tick(1);
    check("cpu_hold after drop edge", cpu_hold, 0);
    send_byte(8'h5A);
    send_byte(8'h22);
    send_byte(8'h11);
    tick(3);
    check("drop err pulses", err_cnt, 1);
    check("drop no tx", tx_q.size(), 0);
    check("drop no writes", wr_q.size(), 0);
    upgrade_en = 1'b1;
    tick(2);
    clear_obs();
    send_range(0, frame_q.size() - 1, 0);
    wait_tx(50);
    check_frame("after drop", 8'h06);

    // Reset mid-frame
    clear_obs();
    load_vec(0);
    send_range(0, 6, 0);
    rst = 1'b1;
    tick(1);
    check("rst mid mem_we", mem_we, 0);
    check("rst mid tx_wr_en", tx_wr_en, 0);
    rst = 1'b0;
    tick(4);
    check("rst mid no tx", tx_q.size(), 0);
    clear_obs();
    send_range(0, frame_q.size() - 1, 0);
    wait_tx(50);
    check_frame("after rst", 8'h06);

    // Random frames against the model
    for (int r = 0; r < 40; r++) begin
      clear_obs();
      words_q.delete();
      len = $urandom_range(3, 0);
      for (int k = 0; k < len; k++) words_q.push_back($urandom);
      make_frame(($urandom_range(3, 0) == 0) ? 16'(16'hFFFF - 16'($urandom_range(2, 0)))
                                             : 16'($urandom),
                 ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00);
      for (int k = $urandom_range(2, 0); k > 0; k--) begin
        junk = 8'($urandom);
        if (junk == 8'h5A) junk = 8'h00;
        frame_q.push_front(junk);
      end
      model_frame(resp);
      send_range(0, frame_q.size() - 1, 2);
      wait_tx(50);
      check_frame($sformatf("rand%0d", r), resp);
    end

    check("done/err pulse alignment", bad_pulse, 0);
    check("tx while busy", busy_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_upgrade_loader.md
Name: uart_upgrade_loader

Overview:
- SoC-side responder for the UART firmware-upgrade link: the partner of the host UART that pushes images into the SoC.
- Consumes received bytes from the on-chip UART receiver, parses upgrade frames, and writes 32-bit words into instruction memory.
- Answers each frame with an ACK or NAK byte through the on-chip UART transmitter.
- Holds the CPU in reset while upgrade mode is enabled.

Parameters:
- ADDR_W, 16, word-address width of the memory write port; the address field is truncated to this width.
- TIMEOUT_CYC, 500000, inter-byte timeout in clk cycles (10 ms at 50 MHz); used only with UPG_TIMEOUT_EN.
- SYNC_BYTE, 8'h5A, frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- upgrade_en  in  1  upgrade mode enable, active high (driven from inverted sw_uart_upgrade_b)
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- tx_wr_en  out  1  one-cycle strobe to transmit tx_data
- tx_data  out  8  response byte
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- cpu_hold  out  1  CPU hold/reset request
- done  out  1  one-cycle pulse, frame ACKed
- err  out  1  one-cycle pulse, NAK, abort or timeout

Behaviour:
- Frame format, all multi-byte fields little-endian: SYNC, ADDR[15:0] (2 bytes), LEN[15:0] (2 bytes, word count), LEN×4 data bytes, CSUM.
- CSUM is the XOR of every byte after SYNC, excluding CSUM itself.
- Reset: all outputs 0, state IDLE, checksum accumulator 0, word counter 0.
- cpu_hold is registered and equals upgrade_en delayed by one cycle.
- States: IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, RESP. Each transition is taken on a cycle with rx_valid=1, except RESP.
- IDLE: a byte equal to SYNC_BYTE goes to ADDR0 and clears the accumulator. Any other byte is ignored.
- ADDR0 → ADDR1 → LEN0 → LEN1: each stores its byte and XORs it into the accumulator.
- LEN1: LEN=0 goes to CSUM; otherwise goes to DATA with the word counter set to 0.
- DATA: assembles bytes LSB-first.
  - On the 4th byte, mem_we=1 for exactly one cycle, in the cycle after that byte's rx_valid.
  - mem_addr = (ADDR + word_index) mod 2^ADDR_W; wrap-around is silent.
  - mem_wdata = the assembled word.
  - After word LEN-1 is written, go to CSUM.
- CSUM: compare the received byte with the accumulator and latch ok/bad, then go to RESP.
- Words are written before the checksum is known. On NAK the host resends the frame; memory is not rolled back.
- RESP:
  - On the first cycle with tx_busy=0, tx_wr_en=1 for one cycle with tx_data = 8'h06 (ok) or 8'h15 (bad).
  - done=1 (ok) or err=1 (bad) in that same cycle.
  - Next state IDLE.
  - While tx_busy=1, wait indefinitely. rx_valid bytes received in RESP are dropped.
- Minimum latency from the CSUM byte's rx_valid to tx_wr_en is 2 cycles.
- upgrade_en=0:
  - Any state returns to IDLE on the next cycle.
  - All rx_valid is ignored; no tx and no mem_we.
  - If the block was mid-frame (not IDLE or RESP), err pulses once.
  - A pending RESP is discarded.
- rx_valid and a state change never coincide with mem_we from a prior byte in a way that loses data: one byte is accepted per rx_valid, and back-to-back rx_valid on consecutive cycles must be accepted.
- rst mid-frame: immediate return to IDLE at the clock edge, outputs 0, no response byte.

Optional Feature:
- UPG_TIMEOUT_EN defined: a counter is cleared on every accepted rx_valid and on entry to ADDR0. It increments in ADDR0..CSUM.
  - When it reaches TIMEOUT_CYC with no byte: return to IDLE, pulse err once, send no tx byte.
  - Memory already written is kept.
- UPG_TIMEOUT_EN undefined: no counter logic. The block waits indefinitely for the next byte; TIMEOUT_CYC is unused.

Test Plan:
- Valid 2-word frame: 5A 10 00 02 00 44 33 22 11 EF BE AD DE 74 → mem_we at addr 0x0010 data 0x11223344, then addr 0x0011 data 0xDEADBEEF; tx_data 0x06 with done pulse.
- Bad checksum: same frame with CSUM 75 → both writes still occur; tx_data 0x15 with err pulse, no done.
- Zero length: 5A 00 01 00 00 01 → no mem_we; ACK 0x06.
- Address wrap: 5A FF FF 02 00 + 8 data bytes + correct CSUM → writes at 0xFFFF then 0x0000; ACK.
- Timeout (UPG_TIMEOUT_EN, TIMEOUT_CYC=100): send 5A 10 00, then idle 101 cycles → err pulse, no tx. A following valid frame → ACK. Without the macro, the same stall followed by the remaining bytes completes with ACK.
- Misc:
  - Leading 00 FF before SYNC are ignored and the frame ACKs.
  - tx_busy held high for 50 cycles in RESP delays tx_wr_en until tx_busy falls.
  - upgrade_en dropped mid-DATA → IDLE, err pulse, cpu_hold falls one cycle later, no tx.
  - rx_valid on consecutive cycles is fully accepted.
